fetch_ctrl: RTL

Instruction-fetch controller sitting between the PC register and decode. It consumes the registered `pc`, issues one instruction-memory request at a time over a valid/ready handshake, and returns the fetched word to decode over a valid/ready handshake. It computes `pcNext` for the PC register: hold, +4, or redirect. It discards in-flight responses made stale by a redirect.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// The state encoding is fixed so waveform dumps stay readable across tools.
package fetch_pkg;

    localparam int              XLEN      = 32;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam int              PC_STEP   = 4;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem request, registered
// instruction output to decode, and next-PC selection for the external PC register.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP  = NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcNext,
    input  logic            redirectValid,
    input  logic [XLEN-1:0] redirectTarget,
    output logic            imemReqValid,
    input  logic            imemReqReady,
    output logic [XLEN-1:0] imemReqAddr,
    input  logic            imemRspValid,
    input  logic [XLEN-1:0] imemRspData,
    output logic            instrValid,
    input  logic            instrReady,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instrPc
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            req_accept;
    logic            unused_target_lsbs;

    // Redirect always wins: a request issued under a redirect would fetch a dead path.
    assign imemReqValid = ((state_q == REQ) || ((state_q == HOLD) && instrReady))
                          && !redirectValid;
    assign imemReqAddr  = pc;
    assign req_accept   = imemReqValid && imemReqReady;

    assign unused_target_lsbs = ^redirectTarget[1:0];

    always_comb begin
        if (redirectValid) begin
            pcNext = {redirectTarget[XLEN-1:2], 2'b00};
        end else if (req_accept) begin
            pcNext = pc + XLEN'(PC_STEP);
        end else begin
            pcNext = pc;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_pc_d      = req_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (req_accept) begin
            req_pc_d = pc;
        end

        case (state_q)
            REQ: begin
                if (req_accept) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirectValid) begin
                    // A response arriving with the redirect is stale; otherwise wait it out.
                    state_d = imemRspValid ? REQ : FLUSH;
                end else if (imemRspValid) begin
                    instr_d       = imemRspData;
                    instr_pc_d    = req_pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (redirectValid) begin
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end else if (instrReady) begin
                    instr_valid_d = 1'b0;
                    state_d       = req_accept ? WAIT : REQ;
                end
            end
            FLUSH: begin
                if (imemRspValid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= REQ;
            req_pc_q      <= '0;
            instr_q       <= NOP;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_pc_q      <= req_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign instrValid = instr_valid_q;
    assign instr      = instr_q;
    assign instrPc    = instr_pc_q;

    // Responses are only legal while one is outstanding or being flushed.
    rsp_in_window: assert property (@(posedge clk) disable iff (reset)
        imemRspValid |-> ((state_q == WAIT) || (state_q == FLUSH)));

endmodule
